// File: rtl/spi_config_master.sv
// spi_config_master: mode-0 SPI master with a start/done handshake.
// Optional: SPI_CONFIG_MASTER_LOOPBACK_EN samples mosi instead of miso.
module spi_config_master #(
  parameter int NBITS   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(NBITS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [NBITS-1:0] tx_sr;
  logic [NBITS-1:0] rx_sr;
  logic [NBITS-1:0] tx_next;
  logic [NBITS-1:0] rx_next;
  logic             sample_bit;
  logic             div_last;
  logic             bit_last;

`ifdef SPI_CONFIG_MASTER_LOOPBACK_EN
  // mosi is stable across the rising edge, so it loops back cleanly
  logic unused_miso;
  assign unused_miso = miso;
  assign sample_bit  = mosi;
`else
  assign sample_bit = miso;
`endif

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_cnt == BIT_W'(NBITS - 1));
  assign tx_next  = tx_sr << 1;

  // rx shift: new bit enters at the LSB, first bit ends at the MSB
  if (NBITS > 1) begin : g_rx_wide
    assign rx_next = {rx_sr[NBITS-2:0], sample_bit};
  end else begin : g_rx_one
    assign rx_next = sample_bit;
  end

  // Frame sequencer: half-period timing, bit shifting and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk <= 1'b0;
          mosi <= 1'b0;
          if (start) begin
            tx_sr   <= tx_data;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            mosi    <= tx_data[NBITS-1];
            state   <= LOW;
          end
        end
        LOW: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            rx_sr   <= rx_next;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (bit_last) begin
              rx_data <= rx_sr;
              done    <= 1'b1;
              busy    <= 1'b0;
              mosi    <= 1'b0;
              state   <= IDLE;
            end else begin
              tx_sr   <= tx_next;
              mosi    <= tx_next[NBITS-1];
              bit_cnt <= bit_cnt + 1'b1;
              state   <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// tb_spi_config_master: random frames against a frame-schedule model.
// A bench-side mode-0 slave replies with words from reply_tab.
module tb_spi_config_master;

  localparam int N  = 8;
  localparam int C  = 2;
  localparam int FL = 2 * C * N;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sclk;
  logic       mosi;
  logic       miso;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_config_master #(
    .NBITS  (N),
    .CLK_DIV(C)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .tx_data(tx_data),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso)
  );

  // slave: presents reply MSB first, advances on each sclk fall
  logic [7:0] reply_tab [0:63];
  logic [2:0] sl_bit = 3'd0;
  logic [5:0] sl_frames = 6'd0;
  logic       force_one = 1'b0;

  assign miso = force_one ? 1'b1 : reply_tab[sl_frames][3'd7 - sl_bit];

  always @(negedge sclk or posedge rst) begin
    if (rst) begin
      sl_bit = 3'd0;
    end else begin
      if (sl_bit == 3'd7) sl_frames = sl_frames + 6'd1;
      sl_bit = sl_bit + 3'd1;
    end
  end

  // model: frame schedule relative to the accepting edge t0
  int         e = 0;
  int         t0 = -1000;
  logic       m_act = 1'b0;
  logic [7:0] m_w = 8'h00;
  logic [7:0] m_r = 8'h00;
  logic [7:0] m_rx = 8'h00;

  function automatic bit m_busy(int c);
    return m_act && (c - t0) >= 1 && (c - t0) <= FL;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
      m_rx  = 8'h00;
    end else begin
      if (start && !m_busy(e)) begin
        t0    = e;
        m_act = 1'b1;
        m_w   = tx_data;
`ifdef SPI_CONFIG_MASTER_LOOPBACK_EN
        m_r   = tx_data;
`else
        m_r   = force_one ? 8'hFF : reply_tab[sl_frames];
`endif
      end
      e = e + 1;
      if (m_act && (e - t0) == FL + 1) m_rx = m_r;
    end
  end

  task automatic check_cycle();
    int   k;
    logic eb, ed, es, em;
    logic [11:0] got, want;
    k  = e - t0;
    eb = 1'b0;
    ed = 1'b0;
    es = 1'b0;
    em = 1'b0;
    if (m_act && k >= 1 && k <= FL) begin
      eb = 1'b1;
      es = ((k - 1) % (2 * C)) >= C;
      em = m_w[3'(7 - (k - 1) / (2 * C))];
    end else if (m_act && k == FL + 1) begin
      ed = 1'b1;
    end
    got  = {busy, done, sclk, mosi, rx_data};
    want = {eb, ed, es, em, m_rx};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL cycle e=%0d busy,done,sclk,mosi,rx got %b %b %b %b %h want %b %b %b %b %h",
               e, busy, done, sclk, mosi, rx_data, eb, ed, es, em, m_rx);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic frame(input logic [7:0] w, input int inj,
                       output int dn, output int rises, output int lows0,
                       output bit hi_ok, output logic [7:0] mb,
                       output logic [7:0] rx);
    bit ps;
    int hr;
    start   = 1'b1;
    tx_data = w;
    tick();
    start   = 1'b0;
    tx_data = 8'($urandom);
    dn = 0; rises = 0; lows0 = 0; hi_ok = 1'b1;
    mb = 8'h00; rx = 8'h00; ps = 1'b0; hr = 0;
    for (int n = 1; n <= FL + 40; n++) begin
      if (n > 1) tick();
      if (inj != 0 && n == inj) begin
        start   = 1'b1;
        tx_data = 8'hFF;
      end else if (inj != 0 && n == inj + 1) begin
        start = 1'b0;
      end
      if (sclk && !ps) begin
        rises++;
        mb = {mb[6:0], mosi};
      end
      if (sclk) hr++;
      else begin
        if (ps && hr != C) hi_ok = 1'b0;
        hr = 0;
      end
      if (rises == 0 && busy && !sclk) lows0++;
      ps = sclk;
      if (done) begin
        dn = n;
        rx = rx_data;
        break;
      end
    end
    start = 1'b0;
    if (dn == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int         dn, rises, lows0, inj, cnt;
    bit         hi_ok, ps;
    logic [7:0] mb, rx;

    for (int i = 0; i < 64; i++) reply_tab[i] = 8'($urandom);
    reply_tab[0] = 8'h3C;
    reply_tab[1] = 8'hC3;

    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rx", int'(rx_data), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    frame(8'hA5, 10, dn, rises, lows0, hi_ok, mb, rx);
    chk("a5_done_at", dn, FL + 1);
    chk("a5_mosi_bits", int'(mb), 8'hA5);
    chk("a5_rises", rises, 8);
    chk("a5_high_width", int'(hi_ok), 1);
    chk("a5_first_low", lows0, C);
    chk("a5_rx", int'(rx), 8'h3C);

    frame(8'h5A, 0, dn, rises, lows0, hi_ok, mb, rx);
    chk("b2b_first_low", lows0, C);
    chk("b2b_done_at", dn, FL + 1);
    chk("b2b_mosi_bits", int'(mb), 8'h5A);
    chk("b2b_rx", int'(rx), 8'hC3);
    repeat (6) tick();

    start   = 1'b1;
    tx_data = 8'h77;
    tick();
    start = 1'b0;
    cnt = 0;
    ps  = 1'b0;
    for (int n = 0; n < 40 && cnt < 3; n++) begin
      tick();
      if (sclk && !ps) cnt++;
      ps = sclk;
    end
    chk("abort_rises_seen", cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();

    frame(8'h81, 0, dn, rises, lows0, hi_ok, mb, rx);
    chk("post_abort_rises", rises, 8);
    chk("post_abort_mosi", int'(mb), 8'h81);
    repeat (3) tick();

    force_one = 1'b1;
    frame(8'h96, 0, dn, rises, lows0, hi_ok, mb, rx);
`ifdef SPI_CONFIG_MASTER_LOOPBACK_EN
    chk("miso1_rx", int'(rx), 8'h96);
`else
    chk("miso1_rx", int'(rx), 8'hFF);
`endif
    force_one = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 20; i++) begin
      cnt = $urandom_range(0, 4);
      repeat (cnt) tick();
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(2, FL - 1) : 0;
      frame(8'($urandom), inj, dn, rises, lows0, hi_ok, mb, rx);
      chk("rand_rises", rises, 8);
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
